// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds opcode encodings, FSM state type and counter sizing.
// Imported by mul_div_unit; no logic lives here.
package muldiv_pkg;

  localparam int WIDTH_DEFAULT = 16;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  // Down-counter width able to hold the iteration count w itself
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_width(WIDTH_DEFAULT);

endpackage

// File: rtl/mul_div_unit.sv
// Iterative shift-add multiplier / restoring divider; products to hi:lo, quotient lo, remainder hi.
// Latency: done pulses WIDTH edges after the accepting edge (1 edge for divide by zero).
// Backpressure: single op in flight; start ignored while busy or done, caller holds start and stalls on busy.
// Optional feature: define MULDIV_SIGNED_EN for two's-complement operands (sign fix-up at DONE).
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               op_r;
  logic               dz_r;
  // Working registers, kept apart from hi/lo so results stay visible during RUN
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   dvsr;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH:0]     part;
  logic               ge;
  logic [WIDTH-1:0]   rem_nxt;
  logic [WIDTH-1:0]   quo_nxt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_q;
  logic [WIDTH-1:0]   res_r;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

`ifdef MULDIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  // Operand magnitudes; the iteration itself is always unsigned
  always_comb begin
    a_mag = a[WIDTH-1] ? -a : a;
    b_mag = b[WIDTH-1] ? -b : b;
  end

  // Result signs captured at acceptance, applied when hi/lo are written
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
      neg_r <= a[WIDTH-1];
    end
  end
`else
  assign a_mag = a;
  assign b_mag = b;
`endif

  // One shift-add step and one restoring-division step, evaluated every RUN cycle
  always_comb begin
    acc_nxt = acc + (mplier[0] ? mcand : '0);
    part    = {rem, quo[WIDTH-1]};
    ge      = (part >= {1'b0, dvsr});
    rem_nxt = ge ? (part[WIDTH-1:0] - dvsr) : part[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], ge};
  end

  // Final hi/lo values as written on the finishing edge
  always_comb begin
    prod  = acc_nxt;
    res_q = quo_nxt;
    res_r = rem_nxt;
`ifdef MULDIV_SIGNED_EN
    if (neg_q) begin
      prod  = -acc_nxt;
      res_q = -quo_nxt;
    end
    if (neg_r) res_r = -rem_nxt;
`endif
    if (dz_r) begin
      // rem carries the raw dividend when the divisor was zero
      res_hi = rem;
      res_lo = '1;
    end else if (op_r == OP_MUL) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else begin
      res_hi = res_r;
      res_lo = res_q;
    end
  end

  // Control FSM, iteration counter, working registers and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op_r     <= OP_MUL;
      dz_r     <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_RUN;
            cnt      <= CW'(WIDTH);
            op_r     <= op;
            dz_r     <= (op == OP_DIV) && (b == '0);
            acc      <= '0;
            mcand    <= {{WIDTH{1'b0}}, a_mag};
            mplier   <= b_mag;
            rem      <= ((op == OP_DIV) && (b == '0)) ? a : '0;
            quo      <= a_mag;
            dvsr     <= b_mag;
            busy     <= 1'b1;
            div_zero <= 1'b0;
          end
        end
        ST_RUN: begin
          cnt    <= cnt - CW'(1);
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          rem    <= rem_nxt;
          quo    <= quo_nxt;
          if (dz_r || cnt == CW'(1)) begin
            state    <= ST_DONE;
            hi       <= res_hi;
            lo       <= res_lo;
            div_zero <= dz_r;
            done     <= 1'b1;
            busy     <= 1'b0;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
